// File: rtl/control_contador.sv
// control_contador: run sequencer for the up/down modulo counter.
// Drives the counter's enable/direction through a clock-enable prescaler and
// counts terminal-count events until the requested number of wraps is done.
// Optional macro AUTO_REVERSE_EN: after the first leg, turn around once (GIRO)
// and run a second leg of the same length in the opposite direction.
module control_contador #(
   parameter int NUM_W = 4,
   parameter int PRESC = 1
) (
   input  logic             iCLOCK,
   input  logic             iRESET,
   input  logic             iSTART,
   input  logic             iDIR,
   input  logic [NUM_W-1:0] iNUM,
   input  logic             iPAUSE,
   input  logic             iABORT,
   input  logic             iTC,
   output logic             oENABLE,
   output logic             oUP_DOWN,
   output logic             oBUSY,
   output logic             oDONE,
   output logic [NUM_W-1:0] oREMAIN
);
   typedef enum logic [1:0] {
      IDLE,
      RUN,
`ifdef AUTO_REVERSE_EN
      GIRO,
`endif
      FIN
   } state_t;

   localparam logic [7:0] PMAX = 8'(PRESC - 1);

   state_t           state_q, state_d;
   logic [7:0]       presc_q, presc_d;
   logic [NUM_W-1:0] remain_q, remain_d;
   logic             dir_q, dir_d;
`ifdef AUTO_REVERSE_EN
   logic [NUM_W-1:0] num_q, num_d;
   logic             leg2_q, leg2_d;
`endif
   logic             tc_ev, last_ev;

   assign oENABLE  = (state_q == RUN) && !iPAUSE && (presc_q == PMAX);
   assign tc_ev    = iTC && oENABLE;
   assign last_ev  = tc_ev && (remain_q == NUM_W'(1));
   assign oUP_DOWN = dir_q;
   assign oBUSY    = state_q != IDLE;
   assign oDONE    = state_q == FIN;
   assign oREMAIN  = remain_q;

   // next-state: start acceptance, prescaling, TC accounting, abort and turnaround
   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      remain_d = remain_q;
      dir_d    = dir_q;
`ifdef AUTO_REVERSE_EN
      num_d    = num_q;
      leg2_d   = leg2_q;
`endif
      case (state_q)
         IDLE: if (iSTART && iNUM != '0) begin
            state_d  = RUN;
            dir_d    = iDIR;
            remain_d = iNUM;
            presc_d  = '0;
`ifdef AUTO_REVERSE_EN
            num_d    = iNUM;
            leg2_d   = 1'b0;
`endif
         end
         RUN: if (iABORT) begin
            state_d  = IDLE;
            remain_d = '0;
         end else begin
            if (!iPAUSE) presc_d = (presc_q == PMAX) ? '0 : presc_q + 8'd1;
            if (tc_ev) remain_d = remain_q - NUM_W'(1);
`ifdef AUTO_REVERSE_EN
            // direction flips as the first leg ends, while the enable drops
            if (last_ev) begin
               state_d = leg2_q ? FIN : GIRO;
               dir_d   = leg2_q ? dir_q : !dir_q;
            end
`else
            if (last_ev) state_d = FIN;
`endif
         end
`ifdef AUTO_REVERSE_EN
         GIRO: if (iABORT) begin
            state_d  = IDLE;
            remain_d = '0;
         end else begin
            state_d  = RUN;
            remain_d = num_q;
            presc_d  = '0;
            leg2_d   = 1'b1;
         end
`endif
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state register with asynchronous reset to the idle/up/cleared condition
   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         state_q  <= IDLE;
         presc_q  <= '0;
         remain_q <= '0;
         dir_q    <= 1'b1;
`ifdef AUTO_REVERSE_EN
         num_q    <= '0;
         leg2_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         remain_q <= remain_d;
         dir_q    <= dir_d;
`ifdef AUTO_REVERSE_EN
         num_q    <= num_d;
         leg2_q   <= leg2_d;
`endif
      end
   end
endmodule

// File: tb/tb_control_contador.sv
// tb_control_contador: scoreboard bench; two instances (PRESC=1 and PRESC=3),
// each driving a modulo-10 counter model whose TC fires every 10th enable.
module tb_control_contador;
`ifdef AUTO_REVERSE_EN
   localparam int LEGS = 2;
`else
   localparam int LEGS = 1;
`endif

   typedef struct {int cyc; int ens; int bsy;} exp_t;

   logic clk = 0, rst = 1, start = 0, dir = 0, pause = 0, abort = 0, sel = 0;
   logic [3:0] num = 0;
   logic en1, ud1, bsy1, dn1, en3, ud3, bsy3, dn3, tc1, tc3;
   logic [3:0] rem1, rem3;
   int cnt1 = 0, cnt3 = 0, cyc = 0, s = 0;
   int e1 = 0, b1 = 0, e3 = 0, b3 = 0;
   int tot = 0, pass = 0;
   exp_t q1[$], q3[$];

   assign tc1 = cnt1 == 9;
   assign tc3 = cnt3 == 9;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (en1) cnt1 <= (cnt1 == 9) ? 0 : cnt1 + 1;
      if (en3) cnt3 <= (cnt3 == 9) ? 0 : cnt3 + 1;
   end

   control_contador #(.NUM_W(4), .PRESC(1)) u1 (
      .iCLOCK(clk), .iRESET(rst), .iSTART(start && !sel), .iDIR(dir), .iNUM(num),
      .iPAUSE(pause), .iABORT(abort), .iTC(tc1), .oENABLE(en1), .oUP_DOWN(ud1),
      .oBUSY(bsy1), .oDONE(dn1), .oREMAIN(rem1));

   control_contador #(.NUM_W(4), .PRESC(3)) u3 (
      .iCLOCK(clk), .iRESET(rst), .iSTART(start && sel), .iDIR(dir), .iNUM(num),
      .iPAUSE(pause), .iABORT(abort), .iTC(tc3), .oENABLE(en3), .oUP_DOWN(ud3),
      .oBUSY(bsy3), .oDONE(dn3), .oREMAIN(rem3));

   task automatic chk(input string name, input int act, input int exp);
      tot++;
      if (act == exp) pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic to_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic start_run(input logic sel_v, input logic dir_v, input logic [3:0] num_v);
      @(negedge clk);
      sel = sel_v; dir = dir_v; num = num_v; start = 1;
      @(negedge clk);
      start = 0;
      s = cyc;
   endtask

   // monitor: counts busy/enable cycles per run and pops the scoreboard on each done pulse
   always @(negedge clk) begin
      exp_t x;
      if (bsy1) begin b1++; if (en1) e1++; end else begin b1 = 0; e1 = 0; end
      if (bsy3) begin b3++; if (en3) e3++; end else begin b3 = 0; e3 = 0; end
      if (dn1) begin
         if (q1.size() == 0) chk("unexpected_done1", 1, 0);
         else begin
            x = q1.pop_front();
            chk("done1_cycle", cyc, x.cyc);
            chk("done1_enables", e1, x.ens);
            chk("done1_busy_cycles", b1, x.bsy);
         end
      end
      if (dn3) begin
         if (q3.size() == 0) chk("unexpected_done3", 1, 0);
         else begin
            x = q3.pop_front();
            chk("done3_cycle", cyc, x.cyc);
            chk("done3_enables", e3, x.ens);
            chk("done3_busy_cycles", b3, x.bsy);
         end
      end
   end

   initial begin
      int paused_en;
      // reset with a start request pending
      rst = 1; start = 1; num = 3; dir = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0; start = 0; num = 0;
      chk("rst_enable", en1, 0);
      chk("rst_updown", ud1, 1);
      chk("rst_busy", bsy1, 0);
      chk("rst_remain", rem1, 0);
      chk("rst_done", dn1, 0);
      @(negedge clk);
      chk("start_in_reset_busy", bsy1, 0);

      // PRESC=1, up, two wraps, with an ignored start mid-run
      start_run(0, 1, 2);
      q1.push_back('{s + LEGS*20 + LEGS - 1, LEGS*20, LEGS*20 + LEGS});
      chk("t1_remain_start", rem1, 2);
      chk("t1_busy", bsy1, 1);
      chk("t1_first_enable", en1, 1);
      to_cyc(s + 5);
      start = 1; num = 5; dir = 0;
      @(negedge clk);
      start = 0;
      chk("busy_start_remain", rem1, 2);
      chk("busy_start_busy", bsy1, 1);
      chk("busy_start_dir", ud1, 1);
      to_cyc(s + 10);
      chk("t1_remain_after_wrap1", rem1, 1);
      to_cyc(s + 20);
      chk("t1_remain_after_wrap2", rem1, 0);
      to_cyc(s + LEGS*20 + LEGS);
      chk("t1_busy_after", bsy1, 0);
      chk("t1_counter_end", cnt1, 0);

      // zero-length request ignored
      start_run(0, 1, 0);
      chk("num0_busy", bsy1, 0);
      chk("num0_remain", rem1, 0);

      // abort coinciding with the final TC event
      start_run(0, 1, 1);
      to_cyc(s + 9);
      chk("abort_pre_remain", rem1, 1);
      chk("abort_pre_tc_event", int'(en1 && tc1), 1);
      abort = 1;
      @(negedge clk);
      abort = 0;
      chk("abort_busy", bsy1, 0);
      chk("abort_remain", rem1, 0);
      repeat (4) @(negedge clk);

      // PRESC=3, down, one wrap, 7-cycle pause mid-run
      start_run(1, 0, 1);
      q3.push_back('{s + LEGS*30 + LEGS - 1 + 7, LEGS*10, LEGS*30 + LEGS + 7});
      chk("t3_updown", ud3, 0);
      chk("t3_remain", rem3, 1);
      chk("t3_no_enable_early", en3, 0);
      to_cyc(s + 2);
      chk("t3_first_enable", en3, 1);
      @(negedge clk);
      chk("t3_gap_enable", en3, 0);
      to_cyc(s + 10);
      pause = 1;
      paused_en = 0;
      repeat (7) begin
         paused_en += int'(en3);
         @(negedge clk);
      end
      pause = 0;
      chk("t3_paused_enables", paused_en, 0);
      to_cyc(s + LEGS*30 + LEGS + 7);
      chk("t3_busy_after", bsy3, 0);
      chk("t3_counter_end", cnt3, 0);

`ifdef AUTO_REVERSE_EN
      // turnaround: 10 up, one GIRO cycle, 10 down
      start_run(0, 1, 1);
      q1.push_back('{s + 21, 20, 22});
      to_cyc(s + 9);
      chk("giro_pre_updown", ud1, 1);
      to_cyc(s + 10);
      chk("giro_enable", en1, 0);
      chk("giro_updown", ud1, 0);
      chk("giro_busy", bsy1, 1);
      @(negedge clk);
      chk("giro_leg2_remain", rem1, 1);
      chk("giro_leg2_enable", en1, 1);
      to_cyc(s + 22);
      chk("giro_busy_after", bsy1, 0);
`endif

      // asynchronous reset in the middle of a down run
      start_run(0, 0, 3);
      to_cyc(s + 3);
      #1 rst = 1;
      #1;
      chk("async_rst_busy", bsy1, 0);
      chk("async_rst_enable", en1, 0);
      chk("async_rst_remain", rem1, 0);
      chk("async_rst_updown", ud1, 1);
      @(negedge clk);
      rst = 0;
      repeat (5) @(negedge clk);

      chk("pending_dones", q1.size() + q3.size(), 0);
      $display("%0d/%0d checks passed", pass, tot);
      $finish;
   end
endmodule

// File: doc/control_contador.md
# control_contador

Sequencer for the up/down modulo counter. It accepts a run command (direction plus number of full counter wraps), drives the counter's enable and direction inputs with an optional clock-enable prescaler, counts terminal-count events and reports completion. It sits between the control logic and the counter instance. It is the only block that drives the counter's enable and direction inputs.

## Interface
- NUM_W, 4: width of the wrap-count request and of the remaining-count output.
- PRESC, 1: counter advances once every PRESC clocks while running; legal range 1..255.

Ports:
- iCLOCK  in  1  system clock, rising edge.
- iRESET  in  1  asynchronous, active-high reset.
- iSTART  in  1  run request, sampled on the rising edge; honoured only in IDLE.
- iDIR  in  1  direction for the run (1 up, 0 down), sampled with an accepted iSTART.
- iNUM  in  NUM_W  number of terminal-count events to run, sampled with an accepted iSTART.
- iPAUSE  in  1  level; freezes the run while high.
- iABORT  in  1  cancels the current run.
- iTC  in  1  counter oTC.
- oENABLE  out  1  to counter iENABLE.
- oUP_DOWN  out  1  to counter iUP_DOWN.
- oBUSY  out  1  high from the cycle after an accepted start until the return to IDLE.
- oDONE  out  1  one-cycle completion pulse.
- oREMAIN  out  NUM_W  terminal-count events still to go.

## Operation
- Reset values: state IDLE, oENABLE 0, oUP_DOWN 1, oBUSY 0, oDONE 0, oREMAIN 0, prescaler 0.
- States: IDLE, RUN, GIRO (only with the macro), FIN.
- IDLE:
  - iSTART=1 and iNUM≠0 moves to RUN. On that edge, oUP_DOWN←iDIR, oREMAIN←iNUM, prescaler←0.
  - iSTART with iNUM=0 is ignored; the block stays in IDLE with no pulse.
- RUN:
  - oENABLE is combinational: (state==RUN) && !iPAUSE && (prescaler==PRESC-1).
  - The prescaler counts 0..PRESC-1 and wraps. It holds its value while iPAUSE=1.
- TC event: a rising edge where iTC=1 and oENABLE=1. On a TC event, oREMAIN decrements. iTC while oENABLE=0 is ignored.
- Last event: a TC event with oREMAIN==1 moves to FIN (or to GIRO, see Configuration).
- FIN: lasts one cycle. oDONE=1, oENABLE=0, oBUSY=1. Then IDLE.
- iABORT=1 in RUN or GIRO:
  - Moves to IDLE on that edge and clears oREMAIN to 0.
  - oDONE is not pulsed.
  - iABORT has priority over a TC event on the same edge.
  - iABORT in IDLE or FIN has no effect.
- iSTART outside IDLE is ignored; it is not queued.
- oUP_DOWN never changes while oENABLE=1. It keeps its last value in IDLE.

## Timing
- Start accepted at edge k. oBUSY=1 from cycle k+1.
- First oENABLE pulse: cycle k+1 when PRESC=1, otherwise cycle k+PRESC (paused cycles extend this).
- With the counter at its start value, PRESC=P, modulo M, no pause and iNUM=N:
  - the final TC event lands at edge k+N·M·P;
  - oDONE is high during cycle k+N·M·P+1;
  - oBUSY falls after the FIN cycle.
- oREMAIN updates on the edge of the TC event.
- Reset mid-run: all outputs return to their reset values immediately (asynchronous). No oDONE.

## Configuration
- Macro AUTO_REVERSE_EN.
- Defined:
  - The last TC event of the first leg moves to GIRO for one cycle. In GIRO: oENABLE=0, oUP_DOWN inverts, oREMAIN reloads the latched iNUM, prescaler←0.
  - GIRO then moves to RUN for a second leg in the opposite direction. The last TC event of that leg moves to FIN.
  - Total run time is twice the single-leg time plus one cycle.
- Undefined: GIRO does not exist, and a run is a single leg.

## Test plan
- Reset held 2 cycles, then released: oENABLE=0, oUP_DOWN=1, oBUSY=0, oREMAIN=0. A start issued during reset has no effect.
- PRESC=1, modulo-10 counter at 0, iSTART with iDIR=1, iNUM=2:
  - oENABLE high for 20 consecutive cycles;
  - oREMAIN goes 2→1→0;
  - oDONE is a single pulse one cycle after the second wrap;
  - counter ends at 0.
- PRESC=3, iDIR=0, iNUM=1:
  - oENABLE pulses every 3rd cycle, 10 pulses total;
  - iPAUSE high for 7 cycles mid-run freezes the pulses and delays oDONE by exactly 7 cycles.
- iABORT asserted on the same edge as a TC event with oREMAIN=1: state goes to IDLE, oREMAIN=0, no oDONE.
- iSTART while busy, and iSTART with iNUM=0 in IDLE: both ignored; oBUSY and oREMAIN unchanged.
- AUTO_REVERSE_EN defined, iDIR=1, iNUM=1, PRESC=1:
  - 10 up-enables, then one cycle with oENABLE=0 and oUP_DOWN flipping to 0;
  - then 10 down-enables and an oDONE pulse;
  - oBUSY high for 22 cycles.
